bpsk_tx_sequencer: RTL
======================

Name: bpsk_tx_sequencer

Overview:
Transmit-side controller for the BPSK modulator. It accepts 32-bit words over a valid/ready stream and assembles them into 16-word frames in two ping-pong banks. It then sequences the modulator: present frame, pulse ModInt, wait for ModDone, release bank. While one bank transmits, the other can fill, so back-to-back frames incur no refill stall.

Parameters:
WORDS, 16, words per frame; must equal modulator ModData depth
DIV_W, 3, width of output-divider config
CNT_W, 16, width of FramesSent counter
TIMEOUT_CYCLES, 65535, ModDone watchdog limit (used only with BPSK_TX_TIMEOUT_EN)

Ports:
Clk  in  1  system clock; all logic on rising edge
Reset_n  in  1  asynchronous active-low reset
WrValid  in  1  write word valid
WrReady  out  1  write word accepted when WrValid&WrReady
WrData  in  32  frame word
WrLast  in  1  final word of a short frame; remaining words zero-padded
CfgOutDiv  in  DIV_W  requested modulator output divider
ModOutDiv  out  DIV_W  divider to modulator; latched at frame kick
ModData  out  32 x WORDS (unpacked [0:WORDS-1])  frame to modulator
ModInt  out  1  one-cycle frame-start pulse to modulator
ModDone  in  1  modulator completion; rising edge counts
Busy  out  1  TX FSM not IDLE, or any bank FULL
FramesSent  out  CNT_W  completed-frame count, saturating
ErrTimeout  out  1  sticky watchdog flag (0 when feature absent)

Behaviour:
- Reset (async, Reset_n=0): both banks FREE, fill/tx bank pointers=0, word index=0, FSM=IDLE. ModInt=0, ModOutDiv=0, ModData all 0, WrReady=0 while in reset, FramesSent=0, ErrTimeout=0, Busy=0. Reset mid-frame discards all data; no ModInt after release until new frame complete.
- Banks: each has state FREE/FULL, WORDS x 32 storage, and a 5-bit valid count. ModData[i] = (i < count) ? mem[i] : 0. Padding is via this mask, not by clearing memory.
- Fill: WrReady = fill bank FREE (combinational from registered state). Accepted word written at index; index++. Frame completes on acceptance of index WORDS-1 or WrLast=1; count = index+1, bank->FULL, fill pointer toggles, index->0.
- WrLast on index WORDS-1 equals a normal full frame.
- Both banks FULL: WrReady=0; words held by source.
- TX FSM states: IDLE, KICK, WAIT_DONE, RELEASE.
- IDLE: if tx bank FULL -> KICK; latch CfgOutDiv into ModOutDiv.
- KICK: ModInt=1 for exactly this cycle -> WAIT_DONE.
- WAIT_DONE: on ModDone rising edge (registered previous value; ModDone high at kick is not an edge) -> RELEASE.
- RELEASE: tx bank->FREE; tx pointer toggles; FramesSent += 1, saturating at all-ones -> IDLE.
- Latency: final word accepted at edge k -> bank FULL after k -> FSM KICK after k+1; ModInt high in cycle k+1..k+2 (2 edges) if FSM was IDLE.
- ModData mux selects tx bank; stable from KICK through RELEASE. ModOutDiv stable same window; CfgOutDiv changes mid-frame take effect next frame.
- Simultaneous RELEASE of bank X and fill completion of bank Y in one cycle: both take effect. RELEASE freeing the bank the writer waits on: WrReady rises next cycle.
- Frames transmit strictly in fill order.

Optional Feature:
BPSK_TX_TIMEOUT_EN
- Defined: 32-bit watchdog counts cycles in WAIT_DONE. Reaching TIMEOUT_CYCLES without ModDone edge -> RELEASE without incrementing FramesSent; ErrTimeout set sticky until reset.
- Undefined: no counter; WAIT_DONE waits indefinitely; ErrTimeout tied 0.

Test Plan:
- Single frame: 16 words 0x1000_0000+i, ModDone pulse 40 cycles after ModInt -> one ModInt pulse 2 edges after last word; ModData[i]=0x1000_0000+i; FramesSent=1; Busy=0 after.
- Short frame: 5 words, WrLast on 5th -> ModData[0..4]=data, ModData[5..15]=0; FramesSent=1.
- Back-to-back: 3 full frames streamed continuously, ModDone 100 cycles after each kick -> WrReady low only while both banks FULL; 3 ModInt pulses in order; FramesSent=3.
- Divider latch: CfgOutDiv=3 at kick, changed to 5 in WAIT_DONE -> ModOutDiv=3 until next kick, then 5.
- Reset mid-WAIT_DONE with a second bank FULL -> all outputs reset values; no ModInt until new frame written.
- (BPSK_TX_TIMEOUT_EN, TIMEOUT_CYCLES=50) no ModDone -> release after 50 cycles; ErrTimeout=1; FramesSent=0; next frame still kicks.

Source files
------------

// File: rtl/bpsk_tx_sequencer.sv
// BPSK transmit sequencer: two ping-pong frame banks fed by a valid/ready stream,
// drained through the ModInt/ModDone modulator handshake. Define BPSK_TX_TIMEOUT_EN for the ModDone watchdog.
module bpsk_tx_sequencer #(
  parameter int WORDS          = 16,
  parameter int DIV_W          = 3,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             WrValid,
  output logic             WrReady,
  input  logic [31:0]      WrData,
  input  logic             WrLast,
  input  logic [DIV_W-1:0] CfgOutDiv,
  output logic [DIV_W-1:0] ModOutDiv,
  output logic [31:0]      ModData [0:WORDS-1],
  output logic             ModInt,
  input  logic             ModDone,
  output logic             Busy,
  output logic [CNT_W-1:0] FramesSent,
  output logic             ErrTimeout
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int LEN_W = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KICK,
    ST_WAIT_DONE,
    ST_RELEASE
  } tx_state_t;

  tx_state_t        r_state;
  logic [31:0]      r_mem [2][WORDS];
  logic [1:0]       r_full;
  logic [LEN_W-1:0] r_len [2];
  logic             r_fill_ptr;
  logic             r_tx_ptr;
  logic [IDX_W-1:0] r_widx;
  logic             r_done_q;

  logic w_accept;
  logic w_frame_end;
  logic w_release;
  logic w_done_rise;
  logic w_count_frame;

  // The writer sees a free fill bank; gated by the reset pin so the source never handshakes during reset.
  assign WrReady     = Reset_n & ~r_full[r_fill_ptr];
  assign w_accept    = WrValid & WrReady;
  assign w_frame_end = w_accept & (WrLast | (r_widx == IDX_W'(WORDS - 1)));
  assign w_release   = (r_state == ST_RELEASE);
  assign w_done_rise = ModDone & ~r_done_q;
  assign Busy        = (r_state != ST_IDLE) | (|r_full);

  // NOTE: frame storage has no reset; a bank's length register masks stale words out of ModData.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_mem[r_fill_ptr][r_widx] <= WrData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_full     <= '0;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_fill_ptr <= 1'b0;
      r_widx     <= '0;
    end else begin
      if (w_accept) begin
        if (w_frame_end) begin
          r_len[r_fill_ptr]  <= LEN_W'(r_widx) + LEN_W'(1);
          r_full[r_fill_ptr] <= 1'b1;
          r_fill_ptr         <= ~r_fill_ptr;
          r_widx             <= '0;
        end else begin
          r_widx <= r_widx + IDX_W'(1);
        end
      end
      // A bank being released is FULL, the bank being filled is FREE, so the two never collide.
      if (w_release) begin
        r_full[r_tx_ptr] <= 1'b0;
      end
    end
  end

  // NOTE: every output of this combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      ModData[i] = (LEN_W'(i) < r_len[r_tx_ptr]) ? r_mem[r_tx_ptr][i] : '0;
    end
  end

`ifdef BPSK_TX_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_timed_out;

  assign w_count_frame = ~r_timed_out;
`else
  assign w_count_frame = 1'b0 == 1'b0;
  assign ErrTimeout    = 1'b0;

  // Watchdog compiled out: the limit only has meaning when the counter exists.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_tx_ptr   <= 1'b0;
      r_done_q   <= 1'b0;
      ModInt     <= 1'b0;
      ModOutDiv  <= '0;
      FramesSent <= '0;
`ifdef BPSK_TX_TIMEOUT_EN
      r_wdog      <= '0;
      r_timed_out <= 1'b0;
      ErrTimeout  <= 1'b0;
`endif
    end else begin
      r_done_q <= ModDone;
      ModInt   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_tx_ptr]) begin
            r_state   <= ST_KICK;
            ModInt    <= 1'b1;
            ModOutDiv <= CfgOutDiv;
          end
        end
        ST_KICK: begin
          r_state <= ST_WAIT_DONE;
`ifdef BPSK_TX_TIMEOUT_EN
          r_wdog <= '0;
`endif
        end
        ST_WAIT_DONE: begin
          if (w_done_rise) begin
            r_state <= ST_RELEASE;
`ifdef BPSK_TX_TIMEOUT_EN
          end else if (r_wdog == 32'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= ST_RELEASE;
            r_timed_out <= 1'b1;
            ErrTimeout  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 32'd1;
`endif
          end
        end
        ST_RELEASE: begin
          r_state  <= ST_IDLE;
          r_tx_ptr <= ~r_tx_ptr;
          if (w_count_frame && (FramesSent != '1)) begin
            FramesSent <= FramesSent + CNT_W'(1);
          end
`ifdef BPSK_TX_TIMEOUT_EN
          r_timed_out <= 1'b0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
